alu_arbiter: RTL
================

Name: alu_arbiter

Overview:
Shares one combinational ALU instance between NUM_REQ independent requesters. Arbitration is round-robin. Each requester presents an operation (sel, in0, in1) over a valid/ready handshake. The granted operation's result is captured in a single-entry output register and returned over a valid/ready response channel, tagged with the requester ID. The block sits between the issuing controllers and the shared ALU datapath.

Parameters:
DATA_WIDTH, 3, operand width; the result is DATA_WIDTH*2+1 bits, signed.
NUM_REQ, 2, number of requesters (2..8).
ID_W, $clog2(NUM_REQ) with a minimum of 1, width of the response ID tag (derived localparam).

Ports:
clk  in  1  clock; all state updates on the rising edge.
rst  in  1  synchronous, active-high reset.
req_valid  in  NUM_REQ  per-requester request valid.
req_ready  out  NUM_REQ  per-requester grant/accept (combinational).
req_sel  in  NUM_REQ*3  packed opcodes; requester i uses bits [3i+2:3i].
req_in0  in  NUM_REQ*DATA_WIDTH  packed operand A.
req_in1  in  NUM_REQ*DATA_WIDTH  packed operand B.
rsp_valid  out  1  response register holds a result.
rsp_ready  in  1  consumer accepts the response.
rsp_out  out  DATA_WIDTH*2+1  signed ALU result.
rsp_id  out  ID_W  index of the requester that issued the operation.
rsp_dz  out  1  set when the opcode was DIV (3) or MOD (7) and in1 was 0.

Behaviour:
- Reset (sync, rst=1 at a clock edge):
  - rsp_valid=0, rsp_out=0, rsp_id=0, rsp_dz=0.
  - RR pointer is set so requester 0 has highest priority.
  - req_ready is forced to all-0 while rst=1.
- Slot availability: slot_free = !rsp_valid || rsp_ready.
- Grant (combinational):
  - When slot_free, grant goes to the first requester with req_valid=1, searching from the priority pointer upward with wrap-around.
  - req_ready is one-hot on the granted index, or all-0 if no grant.
- Transfer: a request transfers when req_valid[i] && req_ready[i]. Requesters must hold valid and payload stable until ready.
- Latency: exactly 1 cycle. The result, ID and dz flag for an operation transferred in cycle N appear with rsp_valid=1 in cycle N+1.
- Full throughput: with rsp_ready held at 1, one operation completes per cycle.
- Simultaneous drain and accept (rsp_valid=1, rsp_ready=1, new grant): the register is overwritten with the new result and rsp_valid stays 1.
- Drain only (rsp_ready=1, no grant): rsp_valid goes to 0 next cycle. rsp_out and rsp_id hold their last value.
- Backpressure (rsp_valid=1, rsp_ready=0): req_ready is all-0 and rsp_out, rsp_id, rsp_dz are stable.
- RR pointer update: only on a transfer, to (granted index + 1) mod NUM_REQ. It does not change on idle or stalled cycles.
- ALU semantics, with the opcode as the ALU index:
  - 0 add, 1 sub, 2 mul, 3 div, 4 and, 5 or, 6 xor, 7 mod.
  - Operands are zero-extended to the result width.
  - sub wraps modulo 2^(2*DATA_WIDTH+1) and is read as signed.
  - div or mod by 0 returns 0 with rsp_dz=1.
- Reset mid-operation: any pending response is dropped. No partial transfer occurs.

Decomposition:
- Package alu_pkg:
  - alu_op_e enum: OP_ADD=0, OP_SUB, OP_MUL, OP_DIV, OP_AND, OP_OR, OP_XOR, OP_MOD (3 bits).
  - Localparam RES_W(DATA_WIDTH)=2*DATA_WIDTH+1.
- The existing alu module is instantiated unchanged as the datapath.
- One new sub-module, rr_arbiter: parameter N; ports req, en, grant (one-hot), gnt_idx, and the pointer. It owns the pointer register and its synchronous reset.
- alu_arbiter owns the operand mux, the output register and the dz detection.

Test Plan:
1. Req0 only, ADD 3+4, rsp_ready=1 -> req_ready=2'b01 same cycle; next cycle rsp_valid=1, rsp_out=7, rsp_id=0, rsp_dz=0.
2. Both requesters valid continuously, rsp_ready=1, starting from reset -> grants 0,1,0,1 on consecutive cycles; one response per cycle with alternating rsp_id.
3. After one completed op, hold rsp_ready=0 with both requesters valid -> req_ready=0 for 5 cycles with rsp_out stable. Raise rsp_ready -> next requester is granted the same cycle and rsp_valid stays 1.
4. DIV 5/0 -> rsp_out=0, rsp_dz=1. MOD 7%3 -> rsp_out=1, rsp_dz=0. DIV 6/4 -> 1.
5. SUB 1-3 -> rsp_out=-2 (7'h7E). MUL 7*7 -> 49. XOR 5^3 -> 6.
6. Assert rst with rsp_valid=1 pending and both requesters valid -> next cycle rsp_valid=0, rsp_out=0; the first grant after reset goes to requester 0.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU datapath and the requester arbiter around it.
// Holds the opcode encoding and the result-width rule.
package alu_pkg;

    typedef enum logic [2:0] {
        OP_ADD = 3'd0,
        OP_SUB = 3'd1,
        OP_MUL = 3'd2,
        OP_DIV = 3'd3,
        OP_AND = 3'd4,
        OP_OR  = 3'd5,
        OP_XOR = 3'd6,
        OP_MOD = 3'd7
    } alu_op_e;

    // Wide enough for a full product plus a sign bit for subtraction.
    function automatic int res_w(input int data_width);
        return 2 * data_width + 1;
    endfunction

    localparam int DEFAULT_DATA_WIDTH = 3;
    localparam int RES_W = res_w(DEFAULT_DATA_WIDTH);

endpackage

// File: rtl/alu.sv
// Combinational ALU: zero-extended operands, signed result of width 2*DATA_WIDTH+1.
// Division and modulo by zero return 0.
module alu
    import alu_pkg::*;
#(
    parameter int DATA_WIDTH = 3
) (
    input  logic [2:0]                         sel,
    input  logic [DATA_WIDTH-1:0]              in0,
    input  logic [DATA_WIDTH-1:0]              in1,
    output logic signed [res_w(DATA_WIDTH)-1:0] out
);

    localparam int RW = res_w(DATA_WIDTH);

    logic [RW-1:0] a;
    logic [RW-1:0] b;
    logic [RW-1:0] r;

    assign a = RW'(in0);
    assign b = RW'(in1);

    always_comb begin
        r = '0;
        case (alu_op_e'(sel))
            OP_ADD:  r = a + b;
            OP_SUB:  r = a - b;
            OP_MUL:  r = a * b;
            OP_DIV:  r = (b == '0) ? '0 : a / b;
            OP_AND:  r = a & b;
            OP_OR:   r = a | b;
            OP_XOR:  r = a ^ b;
            OP_MOD:  r = (b == '0) ? '0 : a % b;
            default: r = '0;
        endcase
    end

    assign out = signed'(r);

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant searching upward from ptr with wrap-around.
// The pointer advances past the winner only when a grant is issued.
module rr_arbiter #(
    parameter int N  = 2,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [N-1:0]  req,
    input  logic          en,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] gnt_idx,
    output logic [IW-1:0] ptr
);

    logic [IW-1:0] ptr_reg;
    logic          found;
    int            idx;

    always_comb begin
        grant   = '0;
        gnt_idx = '0;
        found   = 1'b0;
        idx     = 0;
        for (int k = 0; k < N; k++) begin
            idx = (int'(ptr_reg) + k) % N;
            if (!found && en && req[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                gnt_idx    = IW'(idx);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_reg <= '0;
        end else if (found) begin
            ptr_reg <= (gnt_idx == IW'(N - 1)) ? '0 : gnt_idx + 1'b1;
        end
    end

    assign ptr = ptr_reg;

endmodule

// File: rtl/alu_arbiter.sv
// Shares one ALU between NUM_REQ requesters; the granted operation's result is
// held in a single-entry response register tagged with the requester index.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int DATA_WIDTH = 3,
    parameter int NUM_REQ    = 2,
    parameter int ID_W       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [NUM_REQ-1:0]                 req_valid,
    output logic [NUM_REQ-1:0]                 req_ready,
    input  logic [NUM_REQ*3-1:0]               req_sel,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]      req_in0,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]      req_in1,
    output logic                               rsp_valid,
    input  logic                               rsp_ready,
    output logic signed [res_w(DATA_WIDTH)-1:0] rsp_out,
    output logic [ID_W-1:0]                    rsp_id,
    output logic                               rsp_dz
);

    localparam int RW = res_w(DATA_WIDTH);

    logic [2:0]            sel_arr [NUM_REQ];
    logic [DATA_WIDTH-1:0] in0_arr [NUM_REQ];
    logic [DATA_WIDTH-1:0] in1_arr [NUM_REQ];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
            assign sel_arr[gi] = req_sel[3*gi +: 3];
            assign in0_arr[gi] = req_in0[DATA_WIDTH*gi +: DATA_WIDTH];
            assign in1_arr[gi] = req_in1[DATA_WIDTH*gi +: DATA_WIDTH];
        end
    endgenerate

    logic                 rsp_valid_reg;
    logic signed [RW-1:0] rsp_out_reg;
    logic [ID_W-1:0]      rsp_id_reg;
    logic                 rsp_dz_reg;

    logic                 slot_free;
    logic                 arb_en;
    logic [NUM_REQ-1:0]   grant;
    logic [ID_W-1:0]      gnt_idx;
    logic [ID_W-1:0]      rr_ptr;
    logic                 transfer;

    logic [2:0]            cur_sel;
    logic [DATA_WIDTH-1:0] cur_in0;
    logic [DATA_WIDTH-1:0] cur_in1;
    logic signed [RW-1:0]  alu_res;
    logic                  dz_next;

    // A slot draining this cycle can be refilled in the same cycle.
    assign slot_free = !rsp_valid_reg || rsp_ready;
    assign arb_en    = slot_free && !rst;

    rr_arbiter #(
        .N  (NUM_REQ),
        .IW (ID_W)
    ) u_arb (
        .clk     (clk),
        .rst     (rst),
        .req     (req_valid),
        .en      (arb_en),
        .grant   (grant),
        .gnt_idx (gnt_idx),
        .ptr     (rr_ptr)
    );

    assign req_ready = grant;
    assign transfer  = |grant;

    assign cur_sel = sel_arr[gnt_idx];
    assign cur_in0 = in0_arr[gnt_idx];
    assign cur_in1 = in1_arr[gnt_idx];

    alu #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_alu (
        .sel (cur_sel),
        .in0 (cur_in0),
        .in1 (cur_in1),
        .out (alu_res)
    );

    assign dz_next = ((alu_op_e'(cur_sel) == OP_DIV) || (alu_op_e'(cur_sel) == OP_MOD))
                     && (cur_in1 == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid_reg <= 1'b0;
            rsp_out_reg   <= '0;
            rsp_id_reg    <= '0;
            rsp_dz_reg    <= 1'b0;
        end else if (transfer) begin
            rsp_valid_reg <= 1'b1;
            rsp_out_reg   <= alu_res;
            rsp_id_reg    <= gnt_idx;
            rsp_dz_reg    <= dz_next;
        end else if (rsp_ready) begin
            rsp_valid_reg <= 1'b0;
        end
    end

    assign rsp_valid = rsp_valid_reg;
    assign rsp_out   = rsp_out_reg;
    assign rsp_id    = rsp_id_reg;
    assign rsp_dz    = rsp_dz_reg;

endmodule
